// File: rtl/cmac_tx_arbiter.sv
// Packet-granular round-robin arbiter merging two 512-bit TX AXI-Stream sources
// onto one CMAC TX stream, with alignment gating and runaway-packet truncation.
module cmac_tx_arbiter #(
    parameter int MAX_BEATS = 150
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_aligned,

    input  logic [511:0] i_s0_tdata,
    input  logic [63:0]  i_s0_tkeep,
    input  logic         i_s0_tuser,
    input  logic         i_s0_tlast,
    input  logic         i_s0_tvalid,
    output logic         o_s0_tready,

    input  logic [511:0] i_s1_tdata,
    input  logic [63:0]  i_s1_tkeep,
    input  logic         i_s1_tuser,
    input  logic         i_s1_tlast,
    input  logic         i_s1_tvalid,
    output logic         o_s1_tready,

    output logic [511:0] o_m_tdata,
    output logic [63:0]  o_m_tkeep,
    output logic         o_m_tuser,
    output logic         o_m_tlast,
    output logic         o_m_tvalid,
    input  logic         i_m_tready,

    output logic [31:0]  o_pkt_count0,
    output logic [31:0]  o_pkt_count1,
    output logic [15:0]  o_trunc_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [11:0] LP_LAST_BEAT = 12'(MAX_BEATS - 1);

    state_t      r_state, w_state_nxt;
    logic        r_grant, w_grant_nxt;
    logic        r_last_grant, w_last_grant_nxt;
    logic [11:0] r_beat, w_beat_nxt;
    logic [31:0] r_pkt_count0, r_pkt_count1;
    logic [15:0] r_trunc_count;

    logic        w_winner;
    logic        w_pkt_done;
    logic        w_trunc;
    logic        w_sg_ready;
    logic        w_at_max;

    logic [511:0] w_sg_tdata;
    logic [63:0]  w_sg_tkeep;
    logic         w_sg_tuser;
    logic         w_sg_tlast;
    logic         w_sg_tvalid;

    assign w_sg_tdata  = r_grant ? i_s1_tdata  : i_s0_tdata;
    assign w_sg_tkeep  = r_grant ? i_s1_tkeep  : i_s0_tkeep;
    assign w_sg_tuser  = r_grant ? i_s1_tuser  : i_s0_tuser;
    assign w_sg_tlast  = r_grant ? i_s1_tlast  : i_s0_tlast;
    assign w_sg_tvalid = r_grant ? i_s1_tvalid : i_s0_tvalid;
    assign w_at_max    = (r_beat == LP_LAST_BEAT);

    // Data and keep pass straight through; only the handshake/sideband bits are gated.
    assign o_m_tdata = w_sg_tdata;
    assign o_m_tkeep = w_sg_tkeep;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_beat_nxt       = r_beat;
        w_winner         = 1'b0;
        w_pkt_done       = 1'b0;
        w_trunc          = 1'b0;
        w_sg_ready       = 1'b0;
        o_m_tvalid       = 1'b0;
        o_m_tlast        = 1'b0;
        o_m_tuser        = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_aligned && (i_s0_tvalid || i_s1_tvalid)) begin
                    w_winner         = (i_s0_tvalid && i_s1_tvalid) ? ~r_last_grant : i_s1_tvalid;
                    w_grant_nxt      = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_beat_nxt       = 12'd0;
                    w_state_nxt      = SEND;
                end
            end
            SEND: begin
                o_m_tvalid = w_sg_tvalid;
                o_m_tlast  = w_sg_tlast | w_at_max;
                o_m_tuser  = w_sg_tuser | (w_at_max & ~w_sg_tlast);
                w_sg_ready = i_m_tready;
                if (w_sg_tvalid && i_m_tready) begin
                    w_beat_nxt = r_beat + 12'd1;
                    if (w_sg_tlast) begin
                        w_pkt_done  = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (w_at_max) begin
                        w_pkt_done  = 1'b1;
                        w_trunc     = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Swallow the tail of a truncated packet so it never reaches the MAC.
                w_sg_ready = 1'b1;
                if (w_sg_tvalid && w_sg_tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Quiet the handshake while reset is held, even in the cycle it first asserts.
        if (i_reset) begin
            o_m_tvalid = 1'b0;
            o_m_tlast  = 1'b0;
            o_m_tuser  = 1'b0;
            w_sg_ready = 1'b0;
        end
    end

    assign o_s0_tready = w_sg_ready & ~r_grant;
    assign o_s1_tready = w_sg_ready &  r_grant;

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_reset) begin
            r_state       <= IDLE;
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_beat        <= 12'd0;
            r_pkt_count0  <= 32'd0;
            r_pkt_count1  <= 32'd0;
            r_trunc_count <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat       <= w_beat_nxt;
            if (w_pkt_done) begin
                if (r_grant) r_pkt_count1 <= r_pkt_count1 + 32'd1;
                else         r_pkt_count0 <= r_pkt_count0 + 32'd1;
            end
            if (w_trunc && (r_trunc_count != 16'hFFFF)) begin
                r_trunc_count <= r_trunc_count + 16'd1;
            end
        end
    end

    assign o_pkt_count0  = r_pkt_count0;
    assign o_pkt_count1  = r_pkt_count1;
    assign o_trunc_count = r_trunc_count;

endmodule

// File: tb/tb_cmac_tx_arbiter.sv
// Bench for cmac_tx_arbiter: queue-driven sources, packet-level round-robin
// reference model, directed and randomized phases.
module tb_cmac_tx_arbiter;

    localparam int MAXB = 4;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         user;
        logic         last;
    } beat_t;

    logic         clk;
    logic         reset;
    logic         aligned;
    logic [511:0] s0_tdata, s1_tdata, m_tdata;
    logic [63:0]  s0_tkeep, s1_tkeep, m_tkeep;
    logic         s0_tuser, s0_tlast, s0_tvalid, s0_tready;
    logic         s1_tuser, s1_tlast, s1_tvalid, s1_tready;
    logic         m_tuser, m_tlast, m_tvalid, m_tready;
    logic [31:0]  pkt_count0, pkt_count1;
    logic [15:0]  trunc_count;

    cmac_tx_arbiter #(.MAX_BEATS(MAXB)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_aligned    (aligned),
        .i_s0_tdata   (s0_tdata),
        .i_s0_tkeep   (s0_tkeep),
        .i_s0_tuser   (s0_tuser),
        .i_s0_tlast   (s0_tlast),
        .i_s0_tvalid  (s0_tvalid),
        .o_s0_tready  (s0_tready),
        .i_s1_tdata   (s1_tdata),
        .i_s1_tkeep   (s1_tkeep),
        .i_s1_tuser   (s1_tuser),
        .i_s1_tlast   (s1_tlast),
        .i_s1_tvalid  (s1_tvalid),
        .o_s1_tready  (s1_tready),
        .o_m_tdata    (m_tdata),
        .o_m_tkeep    (m_tkeep),
        .o_m_tuser    (m_tuser),
        .o_m_tlast    (m_tlast),
        .o_m_tvalid   (m_tvalid),
        .i_m_tready   (m_tready),
        .o_pkt_count0 (pkt_count0),
        .o_pkt_count1 (pkt_count1),
        .o_trunc_count(trunc_count)
    );

    // Source queues (what the sources still have to send) and model state.
    beat_t q0[$], q1[$];
    beat_t mq0[$], mq1[$];
    int    lq0[$], lq1[$];
    beat_t exp_q[$], obs_q[$];
    int    obs_cyc[$];

    int          cyc;
    int          checks;
    int          errors;
    int          rdy_mode;
    int          any_rdy, s1_rdy, both_rdy, mirror_err;
    int unsigned mpc0, mpc1;
    int unsigned mtc;
    bit          m_last_grant;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source drivers: present the queue head after each falling edge, pop it
    // just before the rising edge if the handshake completes.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (q0.size() > 0) begin
                s0_tdata = q0[0].data; s0_tkeep = q0[0].keep;
                s0_tuser = q0[0].user; s0_tlast = q0[0].last; s0_tvalid = 1'b1;
            end else begin
                s0_tdata = '0; s0_tkeep = '0; s0_tuser = 1'b0; s0_tlast = 1'b0; s0_tvalid = 1'b0;
            end
            if (q1.size() > 0) begin
                s1_tdata = q1[0].data; s1_tkeep = q1[0].keep;
                s1_tuser = q1[0].user; s1_tlast = q1[0].last; s1_tvalid = 1'b1;
            end else begin
                s1_tdata = '0; s1_tkeep = '0; s1_tuser = 1'b0; s1_tlast = 1'b0; s1_tvalid = 1'b0;
            end
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 9) < 7);
            endcase
            #3;
            if (!reset && s0_tvalid && s0_tready && q0.size() > 0) void'(q0.pop_front());
            if (!reset && s1_tvalid && s1_tready && q1.size() > 0) void'(q1.pop_front());
        end
    end

    // Output monitor, sampling one time unit before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!reset) begin
                if (s0_tready || s1_tready) any_rdy++;
                if (s1_tready) s1_rdy++;
                if (s0_tready && s1_tready) both_rdy++;
                if (m_tvalid && ((s0_tready | s1_tready) !== m_tready)) mirror_err++;
                if (m_tvalid && m_tready) begin
                    obs_q.push_back(beat_t'{m_tdata, m_tkeep, m_tuser, m_tlast});
                    obs_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gen_pkt(input int src, input int n, input bit to_model);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
            b.keep = {$urandom, $urandom};
            b.user = ($urandom_range(0, 7) == 0);
            b.last = (i == n - 1);
            if (src == 0) q0.push_back(b); else q1.push_back(b);
            if (to_model) begin
                if (src == 0) mq0.push_back(b); else mq1.push_back(b);
            end
        end
        if (to_model) begin
            if (src == 0) lq0.push_back(n); else lq1.push_back(n);
        end
    endtask

    // Packet-level model: round robin over whole packets, truncation to MAXB beats.
    task automatic run_model();
        bit    w;
        int    n;
        beat_t b;
        while (lq0.size() > 0 || lq1.size() > 0) begin
            if (lq0.size() > 0 && lq1.size() > 0) w = ~m_last_grant;
            else                                  w = (lq1.size() > 0);
            m_last_grant = w;
            n = w ? lq1.pop_front() : lq0.pop_front();
            for (int i = 0; i < n; i++) begin
                b = w ? mq1.pop_front() : mq0.pop_front();
                if (i < MAXB) begin
                    if (n > MAXB && i == MAXB - 1) begin
                        b.last = 1'b1;
                        b.user = 1'b1;
                    end
                    exp_q.push_back(b);
                end
            end
            if (w) mpc1++; else mpc0++;
            if (n > MAXB && mtc != 32'hFFFF) mtc++;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while ((obs_q.size() < exp_q.size() || q0.size() > 0 || q1.size() > 0) && k < budget) begin
            tick(1);
            k++;
        end
        tick(2);
        chk({tag, "_in_time"}, 640'(k < budget), 640'(1));
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_beats"}, 640'(obs_q.size()), 640'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 640'(obs_q[i]), 640'(exp_q[i]));
        end
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic check_gaps(input string tag);
        int bad;
        bad = 0;
        for (int i = 1; i < obs_cyc.size() && i < exp_q.size(); i++) begin
            if (obs_cyc[i] - obs_cyc[i-1] != (exp_q[i-1].last ? 2 : 1)) bad++;
        end
        chk({tag, "_gaps"}, 640'(bad), 640'(0));
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_pkt0"},  640'(pkt_count0),  640'(mpc0));
        chk({tag, "_pkt1"},  640'(pkt_count1),  640'(mpc1));
        chk({tag, "_trunc"}, 640'(trunc_count), 640'(mtc));
    endtask

    initial begin
        int t0;
        int k;
        checks = 0; errors = 0; cyc = 0; rdy_mode = 0;
        any_rdy = 0; s1_rdy = 0; both_rdy = 0; mirror_err = 0;
        mpc0 = 0; mpc1 = 0; mtc = 0; m_last_grant = 1'b1;
        reset = 1'b1; aligned = 1'b0; m_tready = 1'b1;
        s0_tdata = '0; s0_tkeep = '0; s0_tuser = 1'b0; s0_tlast = 1'b0; s0_tvalid = 1'b0;
        s1_tdata = '0; s1_tkeep = '0; s1_tuser = 1'b0; s1_tlast = 1'b0; s1_tvalid = 1'b0;

        // Reset state
        tick(3);
        #4;
        chk("rst_s0_tready", 640'(s0_tready), 640'(0));
        chk("rst_s1_tready", 640'(s1_tready), 640'(0));
        chk("rst_m_tvalid",  640'(m_tvalid),  640'(0));
        chk("rst_m_tlast",   640'(m_tlast),   640'(0));
        chk("rst_m_tuser",   640'(m_tuser),   640'(0));
        check_counters("rst");
        tick(1);
        reset = 1'b0;
        aligned = 1'b1;
        tick(2);

        // Single source, 3-beat packet at full throughput
        s1_rdy = 0;
        gen_pkt(0, 3, 1'b1);
        run_model();
        t0 = cyc;
        wait_done("single", 100);
        chk("single_first_cycle", 640'(obs_cyc.size() > 0 ? obs_cyc[0] : -1), 640'(t0 + 2));
        chk("single_last_cycle",  640'(obs_cyc.size() > 2 ? obs_cyc[2] : -1), 640'(t0 + 4));
        chk("single_s1_tready",   640'(s1_rdy), 640'(0));
        compare_stream("single");
        check_counters("single");

        // Fairness: both sources saturated with 2-beat packets
        for (int i = 0; i < 4; i++) begin
            gen_pkt(0, 2, 1'b1);
            gen_pkt(1, 2, 1'b1);
        end
        run_model();
        wait_done("fair", 200);
        check_gaps("fair");
        compare_stream("fair");
        check_counters("fair");

        // Backpressure on a full-length s1 packet
        rdy_mode = 1;
        mirror_err = 0;
        gen_pkt(1, MAXB, 1'b1);
        run_model();
        wait_done("bp", 200);
        chk("bp_tready_mirror", 640'(mirror_err), 640'(0));
        compare_stream("bp");
        check_counters("bp");
        rdy_mode = 0;

        // Truncation of a 6-beat runaway packet, then a single-beat packet
        gen_pkt(0, 6, 1'b1);
        gen_pkt(0, 1, 1'b1);
        run_model();
        wait_done("trunc", 200);
        compare_stream("trunc");
        check_counters("trunc");

        // Randomized mixes under random backpressure
        rdy_mode = 2;
        mirror_err = 0;
        both_rdy = 0;
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(2, 5);
            for (int i = 0; i < k; i++) gen_pkt(0, $urandom_range(1, 6), 1'b1);
            k = $urandom_range(2, 5);
            for (int i = 0; i < k; i++) gen_pkt(1, $urandom_range(1, 6), 1'b1);
            run_model();
            wait_done($sformatf("rand%0d", r), 3000);
            compare_stream($sformatf("rand%0d", r));
            check_counters($sformatf("rand%0d", r));
        end
        chk("rand_tready_mirror", 640'(mirror_err), 640'(0));
        chk("rand_single_tready", 640'(both_rdy), 640'(0));
        rdy_mode = 0;
        tick(2);

        // Alignment gating: no grant while unaligned
        aligned = 1'b0;
        any_rdy = 0;
        gen_pkt(0, 2, 1'b1);
        tick(20);
        chk("unaligned_no_beats",  640'(obs_q.size()), 640'(0));
        chk("unaligned_no_tready", 640'(any_rdy), 640'(0));
        aligned = 1'b1;
        run_model();
        wait_done("realign", 100);
        compare_stream("realign");

        // Alignment lost mid-packet: packet completes, then no new grant
        gen_pkt(0, MAXB, 1'b1);
        run_model();
        k = 0;
        while (obs_q.size() < 1 && k < 50) begin
            tick(1);
            k++;
        end
        aligned = 1'b0;
        wait_done("drop_mid", 100);
        compare_stream("drop_mid");
        any_rdy = 0;
        gen_pkt(1, 2, 1'b1);
        tick(15);
        chk("drop_hold_no_beats",  640'(obs_q.size()), 640'(0));
        chk("drop_hold_no_tready", 640'(any_rdy), 640'(0));
        aligned = 1'b1;
        run_model();
        wait_done("drop_resume", 100);
        compare_stream("drop_resume");
        check_counters("drop");

        // Reset in the middle of a packet
        gen_pkt(0, MAXB, 1'b0);
        k = 0;
        while (obs_q.size() < 2 && k < 50) begin
            tick(1);
            k++;
        end
        chk("midrst_reached_beat2", 640'(obs_q.size() >= 2), 640'(1));
        reset = 1'b1;
        q0.delete();
        q1.delete();
        #4;
        chk("midrst_m_tvalid",  640'(m_tvalid),  640'(0));
        chk("midrst_s0_tready", 640'(s0_tready), 640'(0));
        chk("midrst_s1_tready", 640'(s1_tready), 640'(0));
        tick(1);
        #4;
        mpc0 = 0; mpc1 = 0; mtc = 0; m_last_grant = 1'b1;
        check_counters("midrst");
        chk("midrst_m_tvalid_held", 640'(m_tvalid), 640'(0));
        tick(1);
        obs_q.delete();
        obs_cyc.delete();
        reset = 1'b0;
        gen_pkt(0, 2, 1'b1);
        gen_pkt(1, 2, 1'b1);
        run_model();
        wait_done("post_rst", 100);
        compare_stream("post_rst");
        check_counters("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmac_tx_arbiter.md
# cmac_tx_arbiter

Packet-granular round-robin arbiter that shares one 512-bit CMAC TX AXI-Stream between two user-side TX sources, all on the user clock, ahead of the TX clock-domain-crossing FIFO. It never interleaves beats of different packets, holds off new grants while the link is not aligned, and truncates runaway packets. Oversized packets are marked bad via tuser so the CMAC discards them.

## Interface
- MAX_BEATS, 150: maximum beats per packet (150 x 64 B = 9600 B jumbo); range 2..4095
- clk  in  1  user clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- aligned  in  1  PCS-aligned flag, already synchronized to clk
- s0_tdata/s0_tkeep/s0_tuser/s0_tlast/s0_tvalid  in  512/64/1/1/1  source 0 stream
- s0_tready  out  1  source 0 ready
- s1_tdata/s1_tkeep/s1_tuser/s1_tlast/s1_tvalid  in  512/64/1/1/1  source 1 stream
- s1_tready  out  1  source 1 ready
- m_tdata/m_tkeep/m_tuser/m_tlast/m_tvalid  out  512/64/1/1/1  merged stream toward the TX CDC FIFO
- m_tready  in  1  downstream ready
- pkt_count0, pkt_count1  out  32  packets forwarded per source, including truncated ones; wrap modulo 2^32
- trunc_count  out  16  truncation events; saturates at 0xFFFF

## Operation
- State machine with three states: IDLE, SEND, DRAIN. Registers: `grant` (1 bit), `last_grant` (1 bit), `beat` (12 bits).
- IDLE:
  - m_tvalid=0 and s0_tready=s1_tready=0.
  - If aligned=1 and any sX_tvalid=1, choose a winner:
    - If only one source is valid, that source wins.
    - If both are valid, the winner is the source opposite `last_grant`.
  - On a win: `grant`←winner, `last_grant`←winner, `beat`←0, go to SEND.
  - If aligned=0, stay in IDLE.
- SEND, with g=`grant`:
  - m_tdata/m_tkeep/m_tvalid=sg.
  - m_tlast=sg_tlast | (beat==MAX_BEATS-1).
  - m_tuser=sg_tuser | (beat==MAX_BEATS-1 & ~sg_tlast).
  - sg_tready=m_tready. The other source's tready=0.
  - On each accepted beat (sg_tvalid & m_tready): `beat`++.
  - Accepted beat with sg_tlast=1: pkt_countg++, go to IDLE.
  - Accepted beat with beat==MAX_BEATS-1 and sg_tlast=0: pkt_countg++, trunc_count++ (saturating), go to DRAIN.
  - Loss of aligned during SEND is ignored; the current packet completes.
- DRAIN:
  - m_tvalid=0, sg_tready=1, the other source's tready=0.
  - Beats from sg are discarded.
  - On sg_tvalid & sg_tlast, go to IDLE.
- Reset: state=IDLE, grant=0, last_grant=1 (so source 0 wins the first tie), beat=0, all counters 0.
- Outputs during and after reset: all sX_tready=0, m_tvalid=0, m_tlast=0, m_tuser=0, counters 0.
- Reset asserted mid-packet: the packet is abandoned with no forced tlast. Downstream recovery is the owner's responsibility.

## Timing
- Datapath is combinational pass-through in SEND: zero-cycle latency, one beat per clock at full throughput.
- Arbitration costs exactly one idle cycle per packet: the IDLE decision cycle, with m_tvalid=0.
- A source's tvalid must be high in the IDLE cycle to be considered. Grant is registered; the first beat is presented on the following cycle.
- Counters update on the clock edge that accepts the final beat and are visible the next cycle.
- Source behaviour under stall:
  - m_tready=0 stalls the granted source only.
  - The non-granted source's tvalid may stay high indefinitely without effect.
- Single-beat packet (tlast on beat 0): SEND lasts one accepted beat, then IDLE.
- Packet of exactly MAX_BEATS beats with tlast on the last beat: normal completion, no truncation.

## Test plan
- Single source: after reset, aligned=1; s0 sends 3-beat packet, m_tready=1 -> m_tvalid on cycles 2,3,4 with identical data, m_tlast on the 3rd beat, pkt_count0=1, s1_tready stays 0.
- Fairness: both sources continuously offer 2-beat packets -> output packet order 0,1,0,1. Exactly one m_tvalid=0 cycle between packets. After 8 packets, pkt_count0=pkt_count1=4.
- Backpressure: m_tready toggles 1,0,1,0 during an s1 packet -> s1_tready mirrors m_tready. No beat is lost or duplicated, and beat order is preserved.
- Truncation: MAX_BEATS=4, s0 sends 6 beats without tlast until beat 6 -> output shows 4 beats with m_tlast=1, m_tuser=1 on beat 4. Beats 5-6 are consumed with m_tvalid=0. trunc_count=1, pkt_count0=1, then back to IDLE.
- Alignment gating: aligned=0 with s0_tvalid=1 -> no grant and tready=0 indefinitely. Drop aligned mid-packet -> the packet completes, then no new grant until aligned=1.
- Reset mid-packet: assert reset on beat 2 of 5 -> next cycle m_tvalid=0, all tready=0, counters 0. After release, s0 wins the first tie.
